// File: rtl/mpu_sample_sequencer.sv
// MPU6050 sample sequencer: issues init and periodic burst-read requests to the I2C master,
// assembles the returned bytes into signed words and supervises the master with a watchdog.
module mpu_sample_sequencer #(
    parameter int unsigned CLK_MAIN         = 50000000,
    parameter int unsigned POWERUP_CYCLES   = 5000000,
    parameter int unsigned SAMPLE_CYCLES    = 50000,
    parameter int unsigned NUM_BYTES        = 14,
    parameter int unsigned TIMEOUT_CYCLES   = 200000,
    parameter int unsigned RST_PULSE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               iic_init,
    output logic               iic_transfer,
    output logic               iic_rst,
    input  logic               iic_busy,
    input  logic               iic_data_valid,
    input  logic [7:0]         iic_data,
    output logic               sample_valid,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic signed [15:0] temp,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic [15:0]        sample_cnt,
    output logic               err_timeout,
    output logic [2:0]         state_dbg
);
    if (CLK_MAIN == 0 || NUM_BYTES < 2 || NUM_BYTES > 14 || (NUM_BYTES % 2) != 0) begin : g_bad_params
        $error("mpu_sample_sequencer: invalid parameters");
    end

    localparam int unsigned PW = $clog2(POWERUP_CYCLES + 1);
    localparam int unsigned SW = $clog2(SAMPLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RW = $clog2(RST_PULSE_CYCLES + 1);

    localparam logic [PW-1:0] PWR_LAST    = PW'(POWERUP_CYCLES - 1);
    localparam logic [PW-1:0] PWR_RESTART = PW'(POWERUP_CYCLES - POWERUP_CYCLES / 16);
    localparam logic [SW-1:0] SAMPLE_MAX  = SW'(SAMPLE_CYCLES);
    localparam logic [TW-1:0] WDOG_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RST_LAST    = RW'(RST_PULSE_CYCLES - 1);
    localparam logic [3:0]    NB_IDX      = 4'(NUM_BYTES);
    localparam logic [3:0]    LAST_IDX    = 4'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        PWRUP     = 3'd0,
        INIT_REQ  = 3'd1,
        INIT_WAIT = 3'd2,
        IDLE      = 3'd3,
        COLLECT   = 3'd4,
        PUBLISH   = 3'd5,
        RECOVER   = 3'd6
    } state_t;

    state_t          state;
    logic [PW-1:0]   pwr_cnt;
    logic [SW-1:0]   period_cnt;
    logic [TW-1:0]   wdog_cnt;
    logic [RW-1:0]   rst_cnt;
    logic [3:0]      byte_idx;
    logic            seen_busy;
    logic [7:0]      byte_q   [NUM_BYTES];
    logic [7:0]      byte_nxt [NUM_BYTES];
    logic [15:0]     word_q   [7];

    // Byte buffer as it will look once the current strobe is stored; lets the final
    // byte feed the published words in the same edge it arrives.
    always_comb begin
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            byte_nxt[i] = (4'(i) == byte_idx) ? iic_data : byte_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= PWRUP;
            pwr_cnt      <= '0;
            period_cnt   <= '0;
            wdog_cnt     <= '0;
            rst_cnt      <= '0;
            byte_idx     <= '0;
            seen_busy    <= 1'b0;
            iic_init     <= 1'b0;
            iic_transfer <= 1'b0;
            iic_rst      <= 1'b0;
            sample_valid <= 1'b0;
            sample_cnt   <= '0;
            err_timeout  <= 1'b0;
            for (int unsigned i = 0; i < NUM_BYTES; i++) byte_q[i] <= '0;
            for (int unsigned k = 0; k < 7; k++) word_q[k] <= '0;
        end else begin
            iic_init     <= 1'b0;
            iic_transfer <= 1'b0;
            sample_valid <= 1'b0;
            if (period_cnt != SAMPLE_MAX) period_cnt <= period_cnt + 1'b1;

            unique case (state)
                PWRUP: begin
                    if (pwr_cnt >= PWR_LAST) state <= INIT_REQ;
                    else                     pwr_cnt <= pwr_cnt + 1'b1;
                end
                INIT_REQ: begin
                    if (enable && !iic_busy) begin
                        iic_init  <= 1'b1;
                        wdog_cnt  <= '0;
                        seen_busy <= 1'b0;
                        state     <= INIT_WAIT;
                    end
                end
                INIT_WAIT: begin
                    if (seen_busy && !iic_busy) begin
                        state <= IDLE;
                    end else if (wdog_cnt == WDOG_LAST) begin
                        err_timeout <= 1'b1;
                        iic_rst     <= 1'b1;
                        rst_cnt     <= '0;
                        state       <= RECOVER;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                        if (iic_busy) seen_busy <= 1'b1;
                    end
                end
                IDLE: begin
                    if (period_cnt == SAMPLE_MAX && enable && !iic_busy) begin
                        iic_transfer <= 1'b1;
                        period_cnt   <= '0;
                        byte_idx     <= '0;
                        wdog_cnt     <= '0;
                        state        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (iic_data_valid && byte_idx < NB_IDX) begin
                        for (int unsigned i = 0; i < NUM_BYTES; i++) byte_q[i] <= byte_nxt[i];
                        byte_idx <= byte_idx + 1'b1;
                    end
                    // Final byte takes priority over a watchdog expiry in the same cycle.
                    if (iic_data_valid && byte_idx == LAST_IDX) begin
                        for (int unsigned k = 0; k < NUM_BYTES / 2; k++) begin
                            word_q[k] <= {byte_nxt[2*k], byte_nxt[2*k+1]};
                        end
                        sample_valid <= 1'b1;
                        sample_cnt   <= sample_cnt + 1'b1;
                        state        <= PUBLISH;
                    end else if (wdog_cnt == WDOG_LAST) begin
                        err_timeout <= 1'b1;
                        iic_rst     <= 1'b1;
                        rst_cnt     <= '0;
                        state       <= RECOVER;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end
                PUBLISH: begin
                    state <= IDLE;
                end
                RECOVER: begin
                    if (rst_cnt == RST_LAST) begin
                        iic_rst <= 1'b0;
                        pwr_cnt <= PWR_RESTART;
                        state   <= PWRUP;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

    assign accel_x   = word_q[0];
    assign accel_y   = word_q[1];
    assign accel_z   = word_q[2];
    assign temp      = word_q[3];
    assign gyro_x    = word_q[4];
    assign gyro_y    = word_q[5];
    assign gyro_z    = word_q[6];
    assign state_dbg = state;
endmodule

// File: tb/tb_mpu_sample_sequencer.sv
// Randomized self-checking bench for mpu_sample_sequencer, with a scripted I2C master and
// a word/counter reference model built from the byte stream.
module tb_mpu_sample_sequencer;
    localparam int P  = 64;
    localparam int S  = 40;
    localparam int NB = 14;
    localparam int T  = 1000;
    localparam int RP = 4;

    typedef logic [7:0] bytes_t [$];

    logic clk = 1'b0;
    logic rst, enable, iic_busy, iic_data_valid;
    logic [7:0] iic_data;
    logic iic_init, iic_transfer, iic_rst, sample_valid, err_timeout;
    logic signed [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
    logic [15:0] sample_cnt;
    logic [2:0]  state_dbg;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int n_init = 0, n_xfer = 0, n_sv = 0, n_overlap = 0;
    logic [6:0][15:0] exp_words = '0;
    int exp_cnt = 0;
    logic [6:0][15:0] got;

    mpu_sample_sequencer #(
        .CLK_MAIN(50000000), .POWERUP_CYCLES(P), .SAMPLE_CYCLES(S),
        .NUM_BYTES(NB), .TIMEOUT_CYCLES(T), .RST_PULSE_CYCLES(RP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .iic_init(iic_init), .iic_transfer(iic_transfer), .iic_rst(iic_rst),
        .iic_busy(iic_busy), .iic_data_valid(iic_data_valid), .iic_data(iic_data),
        .sample_valid(sample_valid),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .sample_cnt(sample_cnt), .err_timeout(err_timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (iic_init) n_init++;
        if (iic_transfer) n_xfer++;
        if (sample_valid) n_sv++;
        if ((iic_init && iic_transfer) || ((iic_init || iic_transfer) && iic_rst)) n_overlap++;
    end
    assign got = {gyro_z, gyro_y, gyro_x, temp, accel_z, accel_y, accel_x};

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_publish(input bytes_t bq);
        for (int k = 0; k < NB / 2; k++) exp_words[k] = {bq[2*k], bq[2*k+1]};
        exp_cnt = (exp_cnt + 1) % 65536;
    endfunction

    function automatic bytes_t rand_bytes();
        bytes_t bq;
        for (int i = 0; i < NB; i++) bq.push_back(8'($urandom));
        return bq;
    endfunction

    task automatic wait_xfer(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (iic_transfer) seen = 1;
            else tick();
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL wait_xfer: iic_transfer=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic send_bytes(input bytes_t bq, input int max_gap);
        foreach (bq[i]) begin
            repeat ($urandom_range(0, max_gap)) tick();
            iic_data_valid = 1'b1;
            iic_data = bq[i];
            tick();
            iic_data_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n = 0;
        rst = 1'b1; enable = 1'b1; iic_busy = 1'b0; iic_data_valid = 1'b0; iic_data = '0;
        repeat (3) tick();
        tests_run++;
        if ({iic_init, iic_transfer, iic_rst, sample_valid, err_timeout} !== 5'b0 ||
            sample_cnt !== 16'h0 || got !== '0 || state_dbg !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: flags=%b cnt=%h words=%h state=%0d, required all 0",
                     {iic_init, iic_transfer, iic_rst, sample_valid, err_timeout}, sample_cnt, got, state_dbg);
        end
        rst = 1'b0;
        do begin tick(); n++; end while (!iic_init && n < P + 20);
        tests_run++;
        if (n !== P + 1) begin
            tests_failed++;
            $display("FAIL init_latency: iic_init after %0d cycles, required %0d", n, P + 1);
        end
    endtask

    task automatic test_init();
        tick();
        tests_run++;
        if (iic_init !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_pulse_width: iic_init=%b one cycle later, required 0", iic_init);
        end
        iic_busy = 1'b1;
        repeat (300) tick();
        tests_run++;
        if (n_xfer !== 0 || n_init !== 1) begin
            tests_failed++;
            $display("FAIL init_busy: transfers=%0d inits=%0d while busy, required 0 and 1", n_xfer, n_init);
        end
        iic_busy = 1'b0;
    endtask

    task automatic test_read();
        bytes_t bq;
        int sv0;
        for (int r = 0; r < 5; r++) begin
            if (r == 0) begin
                bq = {};
                for (int i = 1; i <= NB; i++) bq.push_back(8'(i));
            end else begin
                bq = rand_bytes();
            end
            wait_xfer(S + 20);
            iic_busy = 1'b1;
            sv0 = n_sv;
            send_bytes(bq, 2);
            model_publish(bq);
            tests_run++;
            if (sample_valid !== 1'b1 || sample_cnt !== 16'(exp_cnt)) begin
                tests_failed++;
                $display("FAIL read%0d_publish: sample_valid=%b cnt=%h, required 1 and %h", r, sample_valid, sample_cnt, 16'(exp_cnt));
            end
            for (int k = 0; k < 7; k++) begin
                tests_run++;
                if (got[k] !== exp_words[k]) begin
                    tests_failed++;
                    $display("FAIL read%0d_word%0d: got %h, required %h", r, k, got[k], exp_words[k]);
                end
            end
            if (r == 0) begin
                tests_run++;
                if (accel_x !== 16'sh0102 || temp !== 16'sh0708 || gyro_z !== 16'sh0D0E || sample_cnt !== 16'd1) begin
                    tests_failed++;
                    $display("FAIL read_fixed: ax=%h t=%h gz=%h cnt=%0d, required 0102 0708 0d0e 1", accel_x, temp, gyro_z, sample_cnt);
                end
            end
            tick();
            tests_run++;
            if (sample_valid !== 1'b0 || n_sv !== sv0 + 1) begin
                tests_failed++;
                $display("FAIL read%0d_single_pulse: sample_valid=%b pulses=%0d, required 0 and %0d", r, sample_valid, n_sv - sv0, 1);
            end
            iic_busy = 1'b0;
        end
    endtask

    task automatic test_coincident();
        bytes_t bq = rand_bytes();
        bytes_t head = bq[0:NB-2];
        int t0;
        wait_xfer(S + 20);
        t0 = cyc;
        iic_busy = 1'b1;
        send_bytes(head, 2);
        while (cyc < t0 + T - 1) tick();
        iic_data_valid = 1'b1;
        iic_data = bq[NB-1];
        tick();
        iic_data_valid = 1'b0;
        model_publish(bq);
        tests_run++;
        if (sample_valid !== 1'b1 || err_timeout !== 1'b0 || sample_cnt !== 16'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL coincident_publish: sv=%b err=%b cnt=%h, required 1 0 %h", sample_valid, err_timeout, sample_cnt, 16'(exp_cnt));
        end
        for (int k = 0; k < 7; k++) begin
            tests_run++;
            if (got[k] !== exp_words[k]) begin
                tests_failed++;
                $display("FAIL coincident_word%0d: got %h, required %h", k, got[k], exp_words[k]);
            end
        end
        repeat (10) tick();
        tests_run++;
        if (err_timeout !== 1'b0 || iic_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincident_no_error: err=%b iic_rst=%b, required 0 0", err_timeout, iic_rst);
        end
        iic_busy = 1'b0;
    endtask

    task automatic test_back_to_back();
        bytes_t bq = rand_bytes();
        int sv0, x0, t1, t2;
        wait_xfer(S + 20);
        iic_busy = 1'b1;
        send_bytes(bq, 1);
        model_publish(bq);
        tick();
        sv0 = n_sv; x0 = n_xfer;
        for (int i = 0; i < 60; i++) begin
            iic_data_valid = 1'b1; iic_data = 8'($urandom); tick();
            iic_data_valid = 1'b0; tick();
        end
        tests_run++;
        if (n_sv !== sv0 || n_xfer !== x0 || got !== exp_words || sample_cnt !== 16'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL stream_ignored: pulses=%0d xfers=%0d cnt=%h, required 0 0 %h", n_sv - sv0, n_xfer - x0, sample_cnt, 16'(exp_cnt));
        end
        enable = 1'b0; iic_busy = 1'b0;
        repeat (20) tick();
        tests_run++;
        if (n_xfer !== x0) begin
            tests_failed++;
            $display("FAIL enable_hold: xfers=%0d with enable low, required 0", n_xfer - x0);
        end
        enable = 1'b1;
        wait_xfer(5);
        t1 = cyc;
        iic_busy = 1'b1;
        bq = rand_bytes();
        send_bytes(bq, 0);
        model_publish(bq);
        tests_run++;
        if (sample_valid !== 1'b1 || got !== exp_words) begin
            tests_failed++;
            $display("FAIL b2b_publish: sv=%b words=%h, required 1 %h", sample_valid, got, exp_words);
        end
        iic_busy = 1'b0;
        wait_xfer(S + 10);
        t2 = cyc;
        tests_run++;
        if (t2 - t1 < S || t2 - t1 > S + 1) begin
            tests_failed++;
            $display("FAIL sample_period: %0d cycles between requests, required %0d..%0d", t2 - t1, S, S + 1);
        end
        iic_busy = 1'b1;
        bq = rand_bytes();
        send_bytes(bq, 1);
        model_publish(bq);
        iic_busy = 1'b0;
    endtask

    task automatic test_wrap();
        bytes_t bq = rand_bytes();
        int sv0;
        repeat (3) tick();
        force dut.sample_cnt = 16'hFFFF;
        tick();
        release dut.sample_cnt;
        exp_cnt = 65535;
        wait_xfer(S + 20);
        iic_busy = 1'b1;
        sv0 = n_sv;
        send_bytes(bq, 2);
        model_publish(bq);
        tests_run++;
        if (sample_valid !== 1'b1 || sample_cnt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL cnt_wrap: sv=%b cnt=%h, required 1 0000", sample_valid, sample_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            iic_data_valid = 1'b1; iic_data = 8'hA5 ^ 8'(i); tick();
        end
        iic_data_valid = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (got !== exp_words || n_sv !== sv0 + 1 || sample_cnt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL extra_strobe: words=%h pulses=%0d cnt=%h, required %h 1 0000", got, n_sv - sv0, sample_cnt, exp_words);
        end
        iic_busy = 1'b0;
    endtask

    task automatic test_timeout();
        bytes_t part = rand_bytes();
        bytes_t bq;
        int t0, c, n, sv0;
        part = part[0:2];
        wait_xfer(S + 20);
        t0 = cyc;
        sv0 = n_sv;
        iic_busy = 1'b1;
        send_bytes(part, 2);
        while (!err_timeout && cyc < t0 + T + 20) tick();
        tests_run++;
        if (cyc - t0 !== T || iic_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_latency: err after %0d cycles iic_rst=%b, required %0d and 1", cyc - t0, iic_rst, T);
        end
        c = 1;
        while (c < 20) begin
            tick();
            if (!iic_rst) break;
            c++;
        end
        tests_run++;
        if (c !== RP) begin
            tests_failed++;
            $display("FAIL rst_pulse_width: iic_rst high %0d cycles, required %0d", c, RP);
        end
        tests_run++;
        if (n_sv !== sv0 || got !== exp_words || sample_cnt !== 16'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL timeout_discard: pulses=%0d words=%h cnt=%h, required 0 %h %h", n_sv - sv0, got, sample_cnt, exp_words, 16'(exp_cnt));
        end
        iic_busy = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!iic_init && n < P);
        tests_run++;
        if (n !== P / 16 + 1) begin
            tests_failed++;
            $display("FAIL reinit_latency: iic_init after %0d cycles, required %0d", n, P / 16 + 1);
        end
        tick();
        iic_busy = 1'b1;
        repeat (20) tick();
        iic_busy = 1'b0;
        bq = rand_bytes();
        wait_xfer(S + 20);
        iic_busy = 1'b1;
        send_bytes(bq, 2);
        model_publish(bq);
        tests_run++;
        if (sample_valid !== 1'b1 || got !== exp_words || err_timeout !== 1'b1) begin
            tests_failed++;
            $display("FAIL recovered_read: sv=%b err=%b words=%h, required 1 1 %h", sample_valid, err_timeout, got, exp_words);
        end
        iic_busy = 1'b0;
    endtask

    task automatic test_mid_reset();
        bytes_t bq = rand_bytes();
        int sv0;
        bq = bq[0:4];
        wait_xfer(S + 20);
        iic_busy = 1'b1;
        send_bytes(bq, 1);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({iic_init, iic_transfer, iic_rst, sample_valid, err_timeout} !== 5'b0 ||
            sample_cnt !== 16'h0 || got !== '0 || state_dbg !== 3'd0) begin
            tests_failed++;
            $display("FAIL async_reset: flags=%b cnt=%h words=%h state=%0d, required all 0",
                     {iic_init, iic_transfer, iic_rst, sample_valid, err_timeout}, sample_cnt, got, state_dbg);
        end
        tick();
        rst = 1'b0;
        iic_busy = 1'b0;
        sv0 = n_sv;
        for (int i = 0; i < 14; i++) begin
            iic_data_valid = 1'b1; iic_data = 8'($urandom); tick();
            iic_data_valid = 1'b0; tick(); tick();
        end
        tests_run++;
        if (n_sv !== sv0 || state_dbg !== 3'd0 || got !== '0 || sample_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL no_partial_publish: pulses=%0d state=%0d words=%h cnt=%h, required 0 0 0 0", n_sv - sv0, state_dbg, got, sample_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_read();
        test_coincident();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_mid_reset();
        tests_run++;
        if (n_overlap !== 0) begin
            tests_failed++;
            $display("FAIL request_rule: %0d overlapping request cycles, required 0", n_overlap);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mpu_sample_sequencer.md
Name: mpu_sample_sequencer

Overview:
Controller that sequences the bit-banged I2C master for the MPU6050 sensor. After power-up it issues one init request, then issues periodic burst-read requests. It assembles the returned bytes into seven signed 16-bit words (accel X/Y/Z, temp, gyro X/Y/Z) and publishes them to the attitude datapath. It also supervises the master with a transaction watchdog and recovers it by pulsing a master-reset output.

Parameters:
CLK_MAIN, 50000000, main clock frequency in Hz.
POWERUP_CYCLES, 5000000, clk cycles to wait after reset before the init request (100 ms).
SAMPLE_CYCLES, 50000, clk cycles between read-request issues (1 kHz).
NUM_BYTES, 14, data bytes per burst read (even, 2..14).
TIMEOUT_CYCLES, 200000, maximum clk cycles from a request to transaction end.
RST_PULSE_CYCLES, 4, width of the iic_rst pulse.

Ports:
clk  in  1  main clock
rst  in  1  asynchronous reset, active-high
enable  in  1  when low, no new requests are issued; an in-flight transaction finishes normally
iic_init  out  1  one-cycle init request to the master
iic_transfer  out  1  one-cycle read request to the master
iic_rst  out  1  active-high reset to the master
iic_busy  in  1  master busy flag
iic_data_valid  in  1  one-cycle byte strobe from the master
iic_data  in  8  received byte
sample_valid  out  1  one-cycle pulse when new words are published
accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z  out  16 each  signed, big-endian assembled
sample_cnt  out  16  published-sample counter; wraps 0xFFFF -> 0
err_timeout  out  1  sticky flag; cleared only by rst
state_dbg  out  3  current state encoding

Behaviour:
- Reset values: all outputs 0; state PWRUP; all counters 0.
- Request rule: iic_init and iic_transfer are never high in the same cycle. Each is asserted only while iic_busy=0 and iic_rst=0.
- States and transitions:
  - PWRUP: count POWERUP_CYCLES, then go to INIT_REQ.
  - INIT_REQ: wait for enable=1 and iic_busy=0. Pulse iic_init for 1 cycle. Clear the watchdog. Go to INIT_WAIT.
  - INIT_WAIT: when iic_busy has been seen high and then falls, go to IDLE. Any iic_data_valid in this state is ignored.
  - IDLE: the period counter increments every cycle from the previous read-request issue, saturating at SAMPLE_CYCLES. When it has reached SAMPLE_CYCLES, enable=1 and iic_busy=0: pulse iic_transfer, reset the period counter and the byte index, and go to COLLECT.
  - COLLECT: on each iic_data_valid with byte index < NUM_BYTES, store iic_data at that index and increment the index. Strobes with index >= NUM_BYTES are ignored. On the cycle the index reaches NUM_BYTES, go to PUBLISH.
  - PUBLISH: one cycle.
    - Word k = {byte[2k], byte[2k+1]}; words beyond NUM_BYTES/2 hold their previous value.
    - Pulse sample_valid and increment sample_cnt in this cycle; output words change in this same cycle.
    - Go to IDLE.
  - RECOVER: drive iic_rst high for RST_PULSE_CYCLES. Then return to PWRUP with a count of POWERUP_CYCLES/16, so the sensor is re-initialized.
- Latency: the last byte strobe lands in cycle N; sample_valid is high in cycle N+1.
- Continuous-read master: the master keeps streaming after its first read request. The sequencer does not re-pulse iic_transfer while iic_busy=1. Once in IDLE with iic_busy still high, each further iic_data_valid is ignored; the period timer still runs and a new request is issued only when busy falls.
- Watchdog: counts cycles in INIT_WAIT and in COLLECT. When it reaches TIMEOUT_CYCLES: set err_timeout, discard partial bytes (outputs unchanged, no sample_valid), and go to RECOVER.
- Simultaneous events: a timeout in the same cycle as the final byte strobe is resolved in favour of the byte, so PUBLISH is taken and no error is raised.
- enable falling in COLLECT: the current sample still completes. enable low in IDLE or INIT_REQ: hold the state; the period counter keeps saturating.
- Reset mid-operation: rst forces all outputs to 0 immediately (asynchronously), including iic_rst=0 and sample_valid=0; state goes to PWRUP.
- Widths: the period and watchdog counters are sized $clog2 of their maximum + 1. The byte index is 4 bits.

Test Plan:
1. Release rst, enable=1, model master with busy high for 300 cycles after iic_init. Expect: iic_init single pulse at cycle POWERUP_CYCLES+1; no iic_transfer before busy falls.
2. Read 14 bytes 0x01..0x0E. Expect: sample_valid one cycle after byte 14; accel_x=0x0102, temp=0x0708, gyro_z=0x0D0E; sample_cnt=1.
3. Master never returns busy low after iic_transfer. Expect: err_timeout=1 at TIMEOUT_CYCLES; iic_rst high exactly 4 cycles; no sample_valid; later a new iic_init.
4. Timeout expiry coincident with the 14th strobe. Expect: sample_valid=1, err_timeout stays 0.
5. Preload sample_cnt to 0xFFFF via 65535 samples (or force). Expect: wrap to 0 on the next publish; the 15th extra strobe after byte 14 is ignored.
6. Assert rst during COLLECT after 5 bytes. Expect: all outputs 0 in the same cycle, state_dbg=PWRUP, no partial publish after release.
